// File: rtl/sdram_pkg.sv
// ---------------------------------------------------------------------------
// sdram_pkg
// Shared definitions for the operational-phase SDRAM controller:
//   - SDRAM command encodings {CS_N, RAS_N, CAS_N, WE_N}
//   - controller state enum
//   - request address field positions (bank / row / column)
//   - default timing values (cycles at 50 MHz)
//   - helper that builds the column address with auto-precharge (A10) set
// ---------------------------------------------------------------------------
package sdram_pkg;

    localparam logic [3:0] CMD_NOP   = 4'b0111;
    localparam logic [3:0] CMD_ACT   = 4'b0011;
    localparam logic [3:0] CMD_READ  = 4'b0101;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_PALL  = 4'b0010;
    localparam logic [3:0] CMD_REF   = 4'b0001;
    localparam logic [3:0] CMD_MRS   = 4'b0000;

    typedef enum logic [3:0] {
        ST_WAIT_INIT,
        ST_IDLE,
        ST_ACT,
        ST_RCD_WAIT,
        ST_WR,
        ST_RD,
        ST_REC,
        ST_REF,
        ST_REF_WAIT
    } ctrl_state_t;

    localparam int ADDR_W      = 24;
    localparam int DATA_W      = 16;
    localparam int DRAM_ADDR_W = 13;

    localparam int BANK_MSB = 23;
    localparam int BANK_LSB = 22;
    localparam int ROW_MSB  = 21;
    localparam int ROW_LSB  = 9;
    localparam int COL_MSB  = 8;
    localparam int COL_LSB  = 0;

    localparam int DEF_T_RCD        = 2;
    localparam int DEF_T_RP         = 2;
    localparam int DEF_T_WR         = 2;
    localparam int DEF_T_RC         = 7;
    localparam int DEF_CAS_LAT      = 2;
    localparam int DEF_BURST_LEN    = 8;
    localparam int DEF_REF_INTERVAL = 390;

    // Column address for READ/WRITE: A10 high requests auto-precharge, A9 unused.
    function automatic logic [DRAM_ADDR_W-1:0] col_addr_ap(input logic [COL_MSB-COL_LSB:0] col);
        return {2'b00, 1'b1, 1'b0, col};
    endfunction

endpackage

// File: rtl/sdram_rw_controller_if.sv
// ---------------------------------------------------------------------------
// sdram_rw_controller_if
// Request/response bus between a client and the SDRAM controller.
//   ireq_valid / oreq_ready : valid/ready handshake (accept on both high at an edge)
//   ireq_we                 : 1 = write, 0 = read
//   ireq_addr               : [23:22] bank, [21:9] row, [8:0] column
//   ireq_wdata              : write data, latched at the handshake
//   ordata / ordata_valid   : first read beat and its one-cycle strobe
// master = client side, slave = controller side.
// ---------------------------------------------------------------------------
interface sdram_rw_controller_if;
    import sdram_pkg::*;

    logic              ireq_valid;
    logic              oreq_ready;
    logic              ireq_we;
    logic [ADDR_W-1:0] ireq_addr;
    logic [DATA_W-1:0] ireq_wdata;
    logic [DATA_W-1:0] ordata;
    logic              ordata_valid;

    modport master (
        output ireq_valid, ireq_we, ireq_addr, ireq_wdata,
        input  oreq_ready, ordata, ordata_valid
    );

    modport slave (
        input  ireq_valid, ireq_we, ireq_addr, ireq_wdata,
        output oreq_ready, ordata, ordata_valid
    );

endinterface

// File: rtl/sdram_refresh_timer.sv
// ---------------------------------------------------------------------------
// sdram_refresh_timer
// Free-running refresh interval counter with a sticky pending flag.
//   iclk, ireset_n       : clock, asynchronous active-low reset
//   i_en                 : count enable (controller out of WAIT_INIT)
//   i_clr                : clears the pending flag (REF command issued)
//   o_ref_pending        : registered pending flag
//   o_ref_pending_next   : value the flag takes at the next edge, so the
//                          controller can register its ready output from it
// ---------------------------------------------------------------------------
module sdram_refresh_timer
    import sdram_pkg::*;
#(
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic iclk,
    input  logic ireset_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_ref_pending,
    output logic o_ref_pending_next
);

    localparam int CW = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;

    logic [CW-1:0] r_count;
    logic          r_pending;
    logic          w_wrap;

    // A wrap that coincides with a clear wins: a new interval has just
    // elapsed, so another refresh is owed. Refreshes never accumulate.
    always_comb begin
        w_wrap             = i_en && (r_count == CW'(REF_INTERVAL - 1));
        o_ref_pending_next = r_pending;
        if (w_wrap) begin
            o_ref_pending_next = 1'b1;
        end else if (i_clr) begin
            o_ref_pending_next = 1'b0;
        end
    end

    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_count   <= '0;
            r_pending <= 1'b0;
        end else begin
            if (i_en) begin
                r_count <= w_wrap ? '0 : r_count + 1'b1;
            end
            r_pending <= o_ref_pending_next;
        end
    end

    assign o_ref_pending = r_pending;

endmodule

// File: rtl/sdram_rw_controller.sv
// ---------------------------------------------------------------------------
// sdram_rw_controller
// Operational-phase SDRAM controller. Takes the command bus after init,
// serves single-word reads/writes (ACTIVATE + READ/WRITE with auto-precharge)
// and inserts AUTO REFRESH every REF_INTERVAL cycles.
//   iclk, ireset_n  : clock, asynchronous active-low reset
//   iinit_done      : init FSM done, only looked at in WAIT_INIT
//   req_if          : request/response bus (slave modport)
//   obusy           : high whenever the controller is not IDLE
//   odram_cmd       : {CS_N, RAS_N, CAS_N, WE_N}
//   odram_addr/ba   : SDRAM address and bank
//   odram_dqm       : {UDQM, LDQM}
//   odram_cke       : clock enable, tied high
//   odram_dq_out/oe : write data and DQ output enable
//   idram_dq_in     : DQ input
// All outputs are registered from the next-state decode, so a state's
// command is on the pins for exactly the cycles that state is current.
// ---------------------------------------------------------------------------
module sdram_rw_controller
    import sdram_pkg::*;
#(
    parameter int T_RCD        = DEF_T_RCD,
    parameter int T_RP         = DEF_T_RP,
    parameter int T_WR         = DEF_T_WR,
    parameter int T_RC         = DEF_T_RC,
    parameter int CAS_LAT      = DEF_CAS_LAT,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int REF_INTERVAL = DEF_REF_INTERVAL
) (
    input  logic                   iclk,
    input  logic                   ireset_n,
    input  logic                   iinit_done,
    sdram_rw_controller_if.slave   req_if,
    output logic                   obusy,
    output logic [3:0]             odram_cmd,
    output logic [DRAM_ADDR_W-1:0] odram_addr,
    output logic [1:0]             odram_ba,
    output logic [1:0]             odram_dqm,
    output logic                   odram_cke,
    output logic [DATA_W-1:0]      odram_dq_out,
    output logic                   odram_dq_oe,
    input  logic [DATA_W-1:0]      idram_dq_in
);

    localparam int CNT_W = 8;

    ctrl_state_t r_state, w_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;

    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              w_accept;
    logic [ADDR_W-1:0] w_addr_sel;

    logic [CAS_LAT-1:0] r_rd_pipe, w_pipe_next;

    logic [3:0]             r_cmd, w_cmd_next;
    logic [DRAM_ADDR_W-1:0] r_dram_addr, w_dram_addr_next;
    logic [1:0]             r_ba, w_ba_next;
    logic [1:0]             r_dqm, w_dqm_next;
    logic [DATA_W-1:0]      r_dq_out, w_dq_out_next;
    logic                   r_dq_oe, w_dq_oe_next;
    logic                   r_ready, w_ready_next;
    logic                   r_busy, w_busy_next;
    logic [DATA_W-1:0]      r_rdata;
    logic                   r_rdata_valid;

    logic w_ref_pending, w_ref_pending_next;

    sdram_refresh_timer #(
        .REF_INTERVAL (REF_INTERVAL)
    ) u_refresh_timer (
        .iclk               (iclk),
        .ireset_n           (ireset_n),
        .i_en               (r_state != ST_WAIT_INIT),
        .i_clr              (r_state == ST_REF),
        .o_ref_pending      (w_ref_pending),
        .o_ref_pending_next (w_ref_pending_next)
    );

    // One bit per cycle after a READ command; the top bit marks the cycle in
    // which the first beat is on DQ. The whole window keeps DQM low.
    assign w_pipe_next = (r_rd_pipe << 1) | CAS_LAT'(r_state == ST_RD);

    // Next-state and next-output decode. Outputs are decoded from the state
    // being entered; ACT uses the live request address because the latch
    // only updates at the same edge.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_WAIT_INIT: begin
                if (iinit_done) w_state_next = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_ref_pending) begin
                    w_state_next = ST_REF;
                end else if (req_if.ireq_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = ST_ACT;
                end
            end
            ST_ACT: begin
                if (T_RCD > 1) begin
                    w_state_next = ST_RCD_WAIT;
                    w_cnt_next   = CNT_W'(T_RCD - 2);
                end else begin
                    w_state_next = r_we ? ST_WR : ST_RD;
                end
            end
            ST_RCD_WAIT: begin
                if (r_cnt == '0) w_state_next = r_we ? ST_WR : ST_RD;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            ST_WR: begin
                w_state_next = ST_REC;
                w_cnt_next   = CNT_W'(T_WR + T_RP - 1);
            end
            ST_RD: begin
                w_state_next = ST_REC;
                w_cnt_next   = CNT_W'(BURST_LEN + T_RP - 1);
            end
            ST_REC, ST_REF_WAIT: begin
                if (r_cnt == '0) w_state_next = ST_IDLE;
                else             w_cnt_next   = r_cnt - 1'b1;
            end
            ST_REF: begin
                w_state_next = ST_REF_WAIT;
                w_cnt_next   = CNT_W'(T_RC - 2);
            end
            default: w_state_next = ST_WAIT_INIT;
        endcase

        w_addr_sel       = w_accept ? req_if.ireq_addr : r_addr;
        w_cmd_next       = CMD_NOP;
        w_dram_addr_next = '0;
        w_ba_next        = '0;
        w_dqm_next       = 2'b11;
        w_dq_out_next    = '0;
        w_dq_oe_next     = 1'b0;
        case (w_state_next)
            ST_ACT: begin
                w_cmd_next       = CMD_ACT;
                w_dram_addr_next = w_addr_sel[ROW_MSB:ROW_LSB];
                w_ba_next        = w_addr_sel[BANK_MSB:BANK_LSB];
            end
            ST_WR: begin
                w_cmd_next       = CMD_WRITE;
                w_dram_addr_next = col_addr_ap(r_addr[COL_MSB:COL_LSB]);
                w_ba_next        = r_addr[BANK_MSB:BANK_LSB];
                w_dqm_next       = 2'b00;
                w_dq_out_next    = r_wdata;
                w_dq_oe_next     = 1'b1;
            end
            ST_RD: begin
                w_cmd_next       = CMD_READ;
                w_dram_addr_next = col_addr_ap(r_addr[COL_MSB:COL_LSB]);
                w_ba_next        = r_addr[BANK_MSB:BANK_LSB];
                w_dqm_next       = 2'b00;
            end
            ST_REF: begin
                w_cmd_next = CMD_REF;
            end
            default: ;
        endcase
        if (|w_pipe_next) w_dqm_next = 2'b00;

        w_ready_next = (w_state_next == ST_IDLE) && !w_ref_pending_next;
        w_busy_next  = (w_state_next != ST_IDLE);
    end

    // State, request latch, read pipeline and registered pin drivers.
    always_ff @(posedge iclk or negedge ireset_n) begin
        if (!ireset_n) begin
            r_state       <= ST_WAIT_INIT;
            r_cnt         <= '0;
            r_we          <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rd_pipe     <= '0;
            r_cmd         <= CMD_NOP;
            r_dram_addr   <= '0;
            r_ba          <= '0;
            r_dqm         <= 2'b11;
            r_dq_out      <= '0;
            r_dq_oe       <= 1'b0;
            r_ready       <= 1'b0;
            r_busy        <= 1'b1;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_rd_pipe   <= w_pipe_next;
            r_cmd       <= w_cmd_next;
            r_dram_addr <= w_dram_addr_next;
            r_ba        <= w_ba_next;
            r_dqm       <= w_dqm_next;
            r_dq_out    <= w_dq_out_next;
            r_dq_oe     <= w_dq_oe_next;
            r_ready     <= w_ready_next;
            r_busy      <= w_busy_next;
            if (w_accept) begin
                r_we    <= req_if.ireq_we;
                r_addr  <= req_if.ireq_addr;
                r_wdata <= req_if.ireq_wdata;
            end
            r_rdata_valid <= r_rd_pipe[CAS_LAT-1];
            if (r_rd_pipe[CAS_LAT-1]) r_rdata <= idram_dq_in;
        end
    end

    assign odram_cmd           = r_cmd;
    assign odram_addr          = r_dram_addr;
    assign odram_ba            = r_ba;
    assign odram_dqm           = r_dqm;
    assign odram_cke           = 1'b1;
    assign odram_dq_out        = r_dq_out;
    assign odram_dq_oe         = r_dq_oe;
    assign obusy               = r_busy;
    assign req_if.oreq_ready   = r_ready;
    assign req_if.ordata       = r_rdata;
    assign req_if.ordata_valid = r_rdata_valid;

endmodule

// File: doc/sdram_rw_controller.md
Name: sdram_rw_controller

Overview:
- Operational-phase SDRAM controller that sits directly downstream of the SDRAM initialization FSM and takes over the SDRAM command bus once that FSM asserts its done flag.
- Accepts single-word read/write requests over a valid/ready handshake and issues ACTIVATE, READ/WRITE with auto-precharge, and periodic AUTO REFRESH.
- Relies on the mode register programmed at init: CAS latency 2, burst length 8, single-location write burst.
- The top level muxes the SDRAM pins between the init block and this block on iinit_done.

Parameters:
- T_RCD, 2: ACTIVATE-to-READ/WRITE delay, in cycles (≥1).
- T_RP, 2: precharge recovery, in cycles.
- T_WR, 2: write recovery before auto-precharge, in cycles.
- T_RC, 7: AUTO REFRESH cycle time, in cycles.
- CAS_LAT, 2: read latency; must match the mode register.
- BURST_LEN, 8: read burst length; must match the mode register.
- REF_INTERVAL, 390: cycles between refreshes (7.8 µs at 50 MHz).

Ports:
- iclk  in  1  system clock
- ireset_n  in  1  asynchronous active-low reset
- iinit_done  in  1  init FSM done flag; sampled only in WAIT_INIT
- ireq_valid  in  1  request valid
- oreq_ready  out  1  request accepted when ireq_valid & oreq_ready at a rising edge
- ireq_we  in  1  1 = write, 0 = read
- ireq_addr  in  24  [23:22] bank, [21:9] row, [8:0] column
- ireq_wdata  in  16  write data
- ordata  out  16  read data
- ordata_valid  out  1  one-cycle strobe qualifying ordata
- obusy  out  1  high whenever state ≠ IDLE
- odram_cmd  out  4  {CS_N, RAS_N, CAS_N, WE_N}
- odram_addr  out  13  SDRAM address
- odram_ba  out  2  bank select
- odram_dqm  out  2  {UDQM, LDQM}
- odram_cke  out  1  constant 1
- odram_dq_out  out  16  write data
- odram_dq_oe  out  1  DQ output enable
- idram_dq_in  in  16  DQ input

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - odram_cmd = NOP (0111), odram_addr = 0, odram_ba = 0, odram_dqm = 11, odram_cke = 1.
  - odram_dq_oe = 0, odram_dq_out = 0, ordata = 0, ordata_valid = 0, oreq_ready = 0, obusy = 1.
  - Refresh timer = 0, ref_pending = 0, state = WAIT_INIT.
- Outputs are registered. The command for a state appears on the pins for exactly the cycles that state is current.
- State machine:
  - WAIT_INIT: drive NOP. Go to IDLE when iinit_done = 1.
  - IDLE: drive NOP, oreq_ready = 1 unless ref_pending. If ref_pending, go to REF; a simultaneous ireq_valid is not accepted. Otherwise, on handshake, latch we/addr/wdata and go to ACT.
  - ACT (1 cycle): cmd 0011, addr = row, ba = bank.
  - RCD_WAIT: NOP for T_RCD-1 cycles; skipped when T_RCD = 1.
  - WR (1 cycle): cmd 0100, addr = {2'b00, 1'b1, 1'b0, col} (A10 = 1, auto-precharge), ba = bank, dq_oe = 1, dq_out = wdata, dqm = 00. Go to REC with count T_WR+T_RP.
  - RD (1 cycle): cmd 0101, same addr/ba encoding as WR, dqm = 00. Go to REC with count BURST_LEN+T_RP.
  - REC: NOP for the loaded count, then IDLE. dqm = 00 for the first CAS_LAT cycles after RD, 11 otherwise.
  - REF (1 cycle): cmd 0001, clear ref_pending.
  - REF_WAIT: NOP for T_RC-1 cycles, then IDLE.
- Read data: capture idram_dq_in as ordata with ordata_valid = 1 for exactly the one cycle that is CAS_LAT+1 cycles after the RD cycle. Only the first beat is returned; the remaining beats are discarded.
- Busy duration after handshake:
  - Write: oreq_ready low for T_RCD+T_WR+T_RP+1 cycles (7 with defaults).
  - Read: oreq_ready low for T_RCD+BURST_LEN+T_RP+1 cycles (13 with defaults).
- Refresh timer:
  - Counts only outside WAIT_INIT. On reaching REF_INTERVAL-1 it sets ref_pending and wraps to 0.
  - If the timer wraps while ref_pending is already set, ref_pending stays set; refreshes are not queued.
  - A refresh pending during an access is serviced in the IDLE cycle after the access completes.
- dq_oe is high only in the WR cycle.
- Once out of WAIT_INIT, iinit_done is ignored.
- Write data is latched at the handshake; ireq_* may change after acceptance without effect.

Decomposition:
- Shared package sdram_pkg contains:
  - Command encodings: CMD_NOP 0111, CMD_ACT 0011, CMD_READ 0101, CMD_WRITE 0100, CMD_PALL 0010, CMD_REF 0001, CMD_MRS 0000.
  - Controller state enum.
  - Address field-slicing constants (bank/row/col MSB and LSB).
  - Default timing values.
- One sub-module, sdram_refresh_timer: counter, wrap, and sticky ref_pending with a clear input.

Test Plan:
- Reset, then iinit_done = 1 after 5 cycles → odram_cmd = 0111 throughout; oreq_ready = 1 exactly one cycle after iinit_done is sampled.
- Write, we = 1, addr = 0x402434, wdata = 0xBEEF → ACT with addr 0x0012, ba 01; one NOP; WRITE with addr 0x0434, dq_out 0xBEEF, dq_oe = 1, dqm 00; oreq_ready low for 7 cycles.
- Read, addr = 0x000005, model returns 0x1234 at CAS_LAT → READ with addr 0x0405; ordata = 0x1234 and ordata_valid pulses 3 cycles after the READ cycle; oreq_ready low for 13 cycles.
- Set REF_INTERVAL = 20 and hold ireq_valid while the refresh timer is due → REF (0001) issued before ACT; no handshake during REF plus the 6 NOP cycles.
- Reset asserted during REC of a read → outputs return to reset values asynchronously; no ordata_valid; state = WAIT_INIT.
- Back-to-back writes with ireq_valid held high → the second handshake occurs in the first IDLE cycle; ACT commands are 8 cycles apart.
